pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush/forward controller for the 5-stage pipeline (IF-ID-EX-MEM-WB).

---
 rtl/pipeline_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for a 5-stage pipeline, with a registered action
// state, a memory-wait watchdog and stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int RA_W        = 5,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [RA_W-1:0]  id_rs1_i,
    input  logic [RA_W-1:0]  id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [RA_W-1:0]  ex_rs1_i,
    input  logic [RA_W-1:0]  ex_rs2_i,
    input  logic [RA_W-1:0]  ex_rd_i,
    input  logic             ex_reg_write_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_branch_taken_i,
    input  logic [RA_W-1:0]  mem_rd_i,
    input  logic             mem_reg_write_i,
    input  logic [RA_W-1:0]  wb_rd_i,
    input  logic             wb_reg_write_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             id_ex_stall_o,
    output logic             ex_mem_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             mem_wb_bubble_o,
    output logic             pc_select_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic [1:0]       state_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LU    = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TO_VAL = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] TO_M1  = WAIT_W'(MEM_TIMEOUT - 1);

    state_t             r_state;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    state_t             w_action;
    logic               w_mem_wait;
    logic               w_load_use;
    logic               w_rs1_hit;
    logic               w_rs2_hit;

    assign w_mem_wait = dmem_req_i & ~dmem_ack_i;
    assign w_rs1_hit  = id_use_rs1_i & (id_rs1_i == ex_rd_i);
    assign w_rs2_hit  = id_use_rs2_i & (id_rs2_i == ex_rd_i);
    assign w_load_use = ex_mem_read_i & ex_reg_write_i & (ex_rd_i != '0) & (w_rs1_hit | w_rs2_hit);

    // A pending memory access outranks a taken branch so the redirect waits for the ack.
    always_comb begin
        w_action = ST_RUN;
        if (w_mem_wait)
            w_action = ST_WAIT;
        else if (ex_branch_taken_i)
            w_action = ST_FLUSH;
        else if (w_load_use)
            w_action = ST_LU;
    end

    always_comb begin
        pc_stall_o      = 1'b0;
        if_id_stall_o   = 1'b0;
        id_ex_stall_o   = 1'b0;
        ex_mem_stall_o  = 1'b0;
        if_id_flush_o   = 1'b0;
        id_ex_flush_o   = 1'b0;
        mem_wb_bubble_o = 1'b0;
        pc_select_o     = 1'b0;
        if (reset_i) begin
            if_id_flush_o   = 1'b1;
            id_ex_flush_o   = 1'b1;
            mem_wb_bubble_o = 1'b1;
        end else begin
            case (w_action)
                ST_WAIT: begin
                    pc_stall_o      = 1'b1;
                    if_id_stall_o   = 1'b1;
                    id_ex_stall_o   = 1'b1;
                    ex_mem_stall_o  = 1'b1;
                    mem_wb_bubble_o = 1'b1;
                end
                ST_FLUSH: begin
                    pc_select_o   = 1'b1;
                    if_id_flush_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                end
                ST_LU: begin
                    pc_stall_o    = 1'b1;
                    if_id_stall_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // MEM/WB forwarding; MEM is younger so it wins, and x0 is never forwarded.
    always_comb begin
        fwd_a_o = 2'b00;
        fwd_b_o = 2'b00;
        if (!reset_i) begin
            if (mem_reg_write_i && mem_rd_i != '0 && mem_rd_i == ex_rs1_i)
                fwd_a_o = 2'b10;
            else if (wb_reg_write_i && wb_rd_i != '0 && wb_rd_i == ex_rs1_i)
                fwd_a_o = 2'b01;
            if (mem_reg_write_i && mem_rd_i != '0 && mem_rd_i == ex_rs2_i)
                fwd_b_o = 2'b10;
            else if (wb_reg_write_i && wb_rd_i != '0 && wb_rd_i == ex_rs2_i)
                fwd_b_o = 2'b01;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_action;
            if (w_mem_wait) begin
                if (r_wait_cnt != TO_VAL)
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                if (r_wait_cnt >= TO_M1)
                    r_timeout <= 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
            if (pc_stall_o)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_action == ST_FLUSH)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign state_o       = r_state;
    assign mem_timeout_o = r_timeout;
    assign stall_cnt_o   = r_stall_cnt;
    assign flush_cnt_o   = r_flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: hazards, forwarding, branch flush,
// memory wait, watchdog timeout and asynchronous reset.
module tb_pipeline_hazard_ctrl;
    logic        clk = 1'b0;
    logic        reset_i;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read, ex_branch_taken;
    logic        mem_reg_write, wb_reg_write, dmem_req, dmem_ack;
    logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic        if_id_flush, id_ex_flush, mem_wb_bubble, pc_select, mem_timeout;
    logic [1:0]  fwd_a, fwd_b, state;
    logic [31:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.RA_W(5), .CNT_W(32), .MEM_TIMEOUT(4)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
        .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_rd_i(ex_rd),
        .ex_reg_write_i(ex_reg_write), .ex_mem_read_i(ex_mem_read),
        .ex_branch_taken_i(ex_branch_taken),
        .mem_rd_i(mem_rd), .mem_reg_write_i(mem_reg_write),
        .wb_rd_i(wb_rd), .wb_reg_write_i(wb_reg_write),
        .dmem_req_i(dmem_req), .dmem_ack_i(dmem_ack),
        .pc_stall_o(pc_stall), .if_id_stall_o(if_id_stall),
        .id_ex_stall_o(id_ex_stall), .ex_mem_stall_o(ex_mem_stall),
        .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
        .mem_wb_bubble_o(mem_wb_bubble), .pc_select_o(pc_select),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .state_o(state),
        .mem_timeout_o(mem_timeout),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs the eight control bits as {pc,ifid_st,idex_st,exmem_st,ifid_fl,idex_fl,bubble,pcsel}.
    function automatic logic [7:0] ctl();
        return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                if_id_flush, id_ex_flush, mem_wb_bubble, pc_select};
    endfunction

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
        ex_branch_taken = 0; mem_rd = 0; mem_reg_write = 0; wb_rd = 0;
        wb_reg_write = 0; dmem_req = 0; dmem_ack = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset_i = 1'b1;
        #1;
        $display("reset: ctl=%b state=%0d", ctl(), state);
        chk("rst_ctl", 32'(ctl()), 32'b0000_1110);
        chk("rst_state", 32'(state), 0);
        chk("rst_cnts", stall_cnt | flush_cnt, 0);
        tick();
        reset_i = 1'b0;
        #1;
        chk("run_ctl", 32'(ctl()), 0);

        // Load-use: EX lw x5, ID add x6,x5,x1
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5;
        id_rs1 = 5; id_use_rs1 = 1; id_rs2 = 1; id_use_rs2 = 1;
        #1;
        $display("load-use: ctl=%b", ctl());
        chk("lu_ctl", 32'(ctl()), 32'b1100_0100);
        tick();
        chk("lu_state", 32'(state), 1);
        chk("lu_stallcnt", stall_cnt, 1);
        id_use_rs1 = 0;
        #1;
        chk("lu_unused_rs", 32'(ctl()), 0);
        ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        #1;
        chk("lu_x0", 32'(ctl()), 0);
        idle();
        tick();
        chk("lu_back_run", 32'(state), 0);
        chk("lu_stallcnt2", stall_cnt, 1);

        // Forwarding
        mem_rd = 3; mem_reg_write = 1; wb_rd = 3; wb_reg_write = 1; ex_rs1 = 3; ex_rs2 = 0;
        #1;
        $display("fwd: a=%b b=%b", fwd_a, fwd_b);
        chk("fwd_a_mem_prio", 32'(fwd_a), 32'b10);
        chk("fwd_b_x0", 32'(fwd_b), 32'b00);
        mem_rd = 0; wb_rd = 3;
        #1;
        chk("fwd_a_wb", 32'(fwd_a), 32'b01);
        mem_rd = 4; mem_reg_write = 0; wb_rd = 4; ex_rs2 = 4;
        #1;
        chk("fwd_b_wb_nomemwr", 32'(fwd_b), 32'b01);
        chk("fwd_a_none", 32'(fwd_a), 32'b00);
        mem_reg_write = 1; wb_rd = 0; ex_rs2 = 0; mem_rd = 0;
        #1;
        chk("fwd_b_zero", 32'(fwd_b), 32'b00);
        idle();

        // Branch taken overriding a load-use hazard
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
        ex_branch_taken = 1;
        #1;
        $display("flush: ctl=%b", ctl());
        chk("fl_ctl", 32'(ctl()), 32'b0000_1101);
        chk("fl_cnt_before", flush_cnt, 0);
        tick();
        chk("fl_state", 32'(state), 3);
        chk("fl_cnt_after", flush_cnt, 1);
        chk("fl_stallcnt", stall_cnt, 1);
        idle();

        // Memory wait with a deferred branch
        dmem_req = 1; ex_branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            $display("mwait %0d: ctl=%b", i, ctl());
            chk("mw_ctl", 32'(ctl()), 32'b1111_0010);
            tick();
            chk("mw_state", 32'(state), 2);
        end
        chk("mw_stallcnt", stall_cnt, 4);
        chk("mw_no_timeout", 32'(mem_timeout), 0);
        dmem_ack = 1;
        #1;
        chk("mw_ack_ctl", 32'(ctl()), 32'b0000_1101);
        tick();
        chk("mw_ack_state", 32'(state), 3);
        chk("mw_ack_flushcnt", flush_cnt, 2);
        chk("mw_ack_stallcnt", stall_cnt, 4);
        idle();
        dmem_ack = 1;
        #1;
        chk("ack_noreq", 32'(ctl()), 0);
        idle();
        tick();

        // Watchdog, MEM_TIMEOUT = 4
        dmem_req = 1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            $display("wd cycle %0d: timeout=%b", i, mem_timeout);
            chk("wd_timeout", 32'(mem_timeout), (i >= 4) ? 32'd1 : 32'd0);
        end
        chk("wd_stallcnt", stall_cnt, 10);
        dmem_ack = 1;
        tick();
        idle();
        tick();
        chk("wd_sticky", 32'(mem_timeout), 1);
        chk("wd_state_run", 32'(state), 0);

        // Reset in the middle of a memory wait
        dmem_req = 1;
        tick();
        chk("rw_state_wait", 32'(state), 2);
        reset_i = 1'b1;
        #1;
        $display("mid reset: ctl=%b state=%0d", ctl(), state);
        chk("rw_state", 32'(state), 0);
        chk("rw_ctl", 32'(ctl()), 32'b0000_1110);
        chk("rw_cnts", stall_cnt | flush_cnt, 0);
        chk("rw_timeout", 32'(mem_timeout), 0);
        tick();
        reset_i = 1'b0;
        idle();
        tick();
        chk("post_rst_state", 32'(state), 0);
        chk("post_rst_stallcnt", stall_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
